// File: rtl/fifo_wptr_full_if.sv
// fifo_wptr_full_if: write-pointer stage bus; slave is the pointer block, master drives w_en and the synced read pointer.
interface fifo_wptr_full_if #(parameter int ADDR_WIDTH = 9);
    logic                  w_en;
    logic [ADDR_WIDTH:0]   g_rptr_sync;
    logic [ADDR_WIDTH:0]   binary_wptr;
    logic [ADDR_WIDTH:0]   g_wptr;
    logic                  w_accept;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    modport slave (
        input  w_en, g_rptr_sync,
        output binary_wptr, g_wptr, w_accept, full, almost_full, fill_level, overflow
    );
    modport master (
        output w_en, g_rptr_sync,
        input  binary_wptr, g_wptr, w_accept, full, almost_full, fill_level, overflow
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side binary/Gray pointers with full, almost-full, fill level and sticky overflow.
module fifo_wptr_full #(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int AF_MARGIN  = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wptr_full_if.slave  bus
);
    localparam int A = ADDR_WIDTH;
    localparam logic [A:0] AF_LEVEL = (A+1)'(DEPTH - AF_MARGIN);
    logic [A:0] b_next, g_next, b_rptr, level;
    assign bus.w_accept = bus.w_en & ~bus.full;
    assign b_next = bus.binary_wptr + {{A{1'b0}}, bus.w_accept};
    assign g_next = b_next ^ (b_next >> 1);
    for (genvar i = 0; i <= A; i++) begin : g_g2b
        assign b_rptr[i] = ^bus.g_rptr_sync[A:i];
    end
    assign level = b_next - b_rptr;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.binary_wptr <= '0;
            bus.g_wptr      <= '0;
            bus.full        <= 1'b0;
            bus.almost_full <= 1'b0;
            bus.fill_level  <= '0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.binary_wptr <= b_next;
            bus.g_wptr      <= g_next;
            // full: writer is exactly one lap ahead of the reader
            bus.full        <= g_next == {~bus.g_rptr_sync[A:A-1], bus.g_rptr_sync[A-2:0]};
            bus.fill_level  <= level;
            bus.almost_full <= level >= AF_LEVEL;
            bus.overflow    <= bus.overflow | (bus.w_en & bus.full);
        end
    end
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: random and directed stimulus checked against an occupancy-arithmetic model.
module tb_fifo_wptr_full;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int wp_m = 0, fill_m = 0, rp = 0;
    bit full_m = 0, af_m = 0, ov_m = 0, started = 0;

    fifo_wptr_full_if #(.ADDR_WIDTH(3)) bus ();
    fifo_wptr_full #(.DEPTH(8), .ADDR_WIDTH(3), .AF_MARGIN(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int ungray(input int g);
        int b = g;
        for (int s = 1; s < 4; s++) b ^= g >> s;
        return b & 15;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy is the lap-aware distance between writer and reader counts.
    always @(posedge clk) begin
        if (rst) begin
            wp_m = 0; fill_m = 0; full_m = 0; af_m = 0; ov_m = 0;
        end else begin
            ov_m = ov_m | (bus.w_en && full_m);
            wp_m = (wp_m + int'(bus.w_en && !full_m)) % 16;
            fill_m = (wp_m - ungray(int'(bus.g_rptr_sync)) + 16) % 16;
            full_m = fill_m == 8;
            af_m = fill_m >= 6;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("binary_wptr", int'(bus.binary_wptr), wp_m);
            check("g_wptr", int'(bus.g_wptr), gray(wp_m));
            check("full", int'(bus.full), int'(full_m));
            check("almost_full", int'(bus.almost_full), int'(af_m));
            check("fill_level", int'(bus.fill_level), fill_m);
            check("overflow", int'(bus.overflow), int'(ov_m));
            check("w_accept", int'(bus.w_accept), int'(bus.w_en && !full_m));
        end
    end

    task automatic tick(input bit we, input int g);
        bus.w_en = we;
        bus.g_rptr_sync = 4'(g);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit we);
        rst = 1'b1;
        tick(we, 0);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] prev_g;
        bus.w_en = 1'b0;
        bus.g_rptr_sync = '0;
        do_reset(0);
        check("rst_wptr", int'(bus.binary_wptr), 0);
        check("rst_flags", int'({bus.full, bus.almost_full, bus.overflow}), 0);
        check("rst_fill", int'(bus.fill_level), 0);
        for (int i = 1; i <= 8; i++) begin
            tick(1, 0);
            if (i == 5) check("af_at5", int'(bus.almost_full), 0);
            if (i == 6) check("af_at6", int'(bus.almost_full), 1);
        end
        check("fill8_wptr", int'(bus.binary_wptr), 8);
        check("fill8_gray", int'(bus.g_wptr), 12);
        check("fill8_full", int'(bus.full), 1);
        check("fill8_level", int'(bus.fill_level), 8);
        for (int i = 0; i < 3; i++) begin
            bus.w_en = 1'b1;
            #1;
            check("full_accept", int'(bus.w_accept), 0);
            tick(1, 0);
        end
        check("ovf_wptr", int'(bus.binary_wptr), 8);
        check("ovf_set", int'(bus.overflow), 1);
        tick(0, 4'b0010);
        check("drain_full", int'(bus.full), 0);
        check("drain_level", int'(bus.fill_level), 5);
        check("drain_af", int'(bus.almost_full), 0);
        check("ovf_sticky", int'(bus.overflow), 1);

        do_reset(0);
        prev_g = bus.g_wptr;
        for (int i = 0; i < 16; i++) begin
            tick(1, gray((i + 15) % 16));
            check("track_full", int'(bus.full), 0);
            check("gray_1bit", $countones(bus.g_wptr ^ prev_g), 1);
            prev_g = bus.g_wptr;
        end
        check("wrap_wptr", int'(bus.binary_wptr), 0);

        do_reset(0);
        for (int i = 0; i < 7; i++) tick(1, 0);
        tick(1, gray(1));
        check("simul_full", int'(bus.full), 0);
        check("simul_level", int'(bus.fill_level), 7);

        do_reset(0);
        rp = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
                rp = 0;
            end else begin
                if (rp != wp_m && $urandom_range(0, 2) == 0) rp = (rp + 1) % 16;
                tick($urandom_range(0, 3) != 0, gray(rp));
            end
        end

        do_reset(0);
        for (int i = 0; i < 5; i++) tick(1, gray(13));
        check("pre_full", int'(bus.full), 1);
        tick(1, gray(13));
        check("pre_ovf", int'(bus.overflow), 1);
        check("pre_wptr", int'(bus.binary_wptr), 5);
        do_reset(1);
        check("mid_rst_wptr", int'(bus.binary_wptr), 0);
        check("mid_rst_gray", int'(bus.g_wptr), 0);
        check("mid_rst_flags", int'({bus.full, bus.almost_full, bus.overflow}), 0);
        check("mid_rst_fill", int'(bus.fill_level), 0);
        tick(0, 0);
        check("mid_rst_hold", int'(bus.binary_wptr), 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
